// File: rtl/sw_input_ctrl_pkg.sv
// Shared constants and bus payload type for the DE0 slide-switch Avalon-MM controller.
package sw_input_ctrl_pkg;

  localparam int unsigned ADDR_W           = 2;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned TICK_DIV_DEFAULT = 50000;
  localparam int unsigned DIV_W_DEFAULT    = 16;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_EDGESEL = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = ADDR_W'(3);

  // Master-to-slave half of an Avalon-MM transfer.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
  } av_cmd_t;

endpackage

// File: rtl/sw_input_ctrl_if.sv
// Avalon-MM slave port bundle for the switch controller.
interface sw_input_ctrl_if;
  import sw_input_ctrl_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, 3-sample tick shift register, debounced output.
module sw_debounce_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic deb
);

  logic       sync1_q;
  logic       sync2_q;
  logic [2:0] samp_q;
  logic [2:0] samp_d;
  logic       deb_q;
  logic       deb_d;

  // The new sample set is judged on the same tick it is shifted in.
  always_comb begin
    samp_d = samp_q;
    deb_d  = deb_q;
    if (tick) begin
      samp_d = {samp_q[1:0], sync2_q};
      if ((&samp_d) || (~|samp_d)) begin
        deb_d = samp_d[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      samp_q  <= 3'b000;
      deb_q   <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/sw_input_ctrl.sv
// Debounced slide-switch register block with per-bit edge capture and maskable level irq.
module sw_input_ctrl
  import sw_input_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned DIV_W    = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  sw_input_ctrl_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  av_cmd_t           cmd_c;
  logic              wr_c;
  logic              tick_c;
  logic              unused_wdata_c;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_d;
  logic [WIDTH-1:0]  deb_c;
  logic [WIDTH-1:0]  deb_dly_q;
  logic [WIDTH-1:0]  hit_c;
  logic [WIDTH-1:0]  clr_c;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  mask_d;
  logic [WIDTH-1:0]  esel_q;
  logic [WIDTH-1:0]  esel_d;
  logic [WIDTH-1:0]  ecap_q;
  logic [WIDTH-1:0]  ecap_d;
  logic              irq_q;
  logic              irq_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  assign cmd_c = '{address:    bus.address,
                   chipselect: bus.chipselect,
                   write_n:    bus.write_n,
                   writedata:  bus.writedata};

  assign wr_c           = cmd_c.chipselect & ~cmd_c.write_n;
  assign tick_c         = (div_q == DIV_W'(TICK_DIV - 1));
  assign unused_wdata_c = ^cmd_c.writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    sw_debounce_bit u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick_c),
      .raw     (in_port[i]),
      .deb     (deb_c[i])
    );
  end

  // Next-state for prescaler, register file, edge capture, irq and read mux.
  always_comb begin
    div_d   = tick_c ? '0 : div_q + DIV_W'(1);
    mask_d  = mask_q;
    esel_d  = esel_q;
    clr_c   = '0;
    rdata_d = '0;

    hit_c = (esel_q & ~deb_c & deb_dly_q) | (~esel_q & deb_c & ~deb_dly_q);

    if (wr_c) begin
      case (cmd_c.address)
        ADDR_IRQMASK: mask_d = cmd_c.writedata[WIDTH-1:0];
        ADDR_EDGESEL: esel_d = cmd_c.writedata[WIDTH-1:0];
        ADDR_EDGECAP: clr_c  = cmd_c.writedata[WIDTH-1:0];
        default:      ;
      endcase
    end

    // A fresh edge overrides a same-cycle clear of that bit.
    ecap_d = (ecap_q & ~clr_c) | hit_c;
    irq_d  = |(ecap_q & mask_q);

    case (cmd_c.address)
      ADDR_DATA:    rdata_d = DATA_W'(deb_c);
      ADDR_IRQMASK: rdata_d = DATA_W'(mask_q);
      ADDR_EDGESEL: rdata_d = DATA_W'(esel_q);
      ADDR_EDGECAP: rdata_d = DATA_W'(ecap_q);
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      deb_dly_q <= '0;
      mask_q    <= '0;
      esel_q    <= '0;
      ecap_q    <= '0;
      irq_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      div_q     <= div_d;
      deb_dly_q <= deb_c;
      mask_q    <= mask_d;
      esel_q    <= esel_d;
      ecap_q    <= ecap_d;
      irq_q     <= irq_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Directed bench for sw_input_ctrl with TICK_DIV = 4: register table plus debounce/edge/irq/reset sequences.
module tb_sw_input_ctrl;
  import sw_input_ctrl_pkg::*;

  localparam int unsigned WIDTH    = 10;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned DIV_W    = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;
  int               checks = 0;
  int               errors = 0;
  int               ecnt;

  sw_input_ctrl_if bus_if ();

  sw_input_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; prescaler ticks fall on edges where ecnt % 4 == 0.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[15];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    step(1);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    step(1);
    data              = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  task automatic expect_rd(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_read(addr, rd);
    check32(name, rd, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          bad;
    int          found;

    vecs[0]  = '{1'b0, ADDR_DATA,    32'h0000_0000, 32'h0000_03FF, 1'b0, "data_init"};
    vecs[1]  = '{1'b1, ADDR_DATA,    32'hFFFF_FFFF, 32'h0,         1'b0, "data_wr"};
    vecs[2]  = '{1'b0, ADDR_DATA,    32'h0000_0000, 32'h0000_03FF, 1'b0, "data_ro"};
    vecs[3]  = '{1'b1, ADDR_IRQMASK, 32'hFFFF_F155, 32'h0,         1'b0, "mask_wr"};
    vecs[4]  = '{1'b0, ADDR_IRQMASK, 32'h0000_0000, 32'h0000_0155, 1'b1, "mask_rw"};
    vecs[5]  = '{1'b1, ADDR_EDGESEL, 32'hA5A5_A2AA, 32'h0,         1'b0, "esel_wr"};
    vecs[6]  = '{1'b0, ADDR_EDGESEL, 32'h0000_0000, 32'h0000_02AA, 1'b1, "esel_rw"};
    vecs[7]  = '{1'b1, ADDR_EDGECAP, 32'h0000_0155, 32'h0,         1'b0, "ecap_wr"};
    vecs[8]  = '{1'b0, ADDR_EDGECAP, 32'h0000_0000, 32'h0000_02AA, 1'b0, "ecap_w1c"};
    vecs[9]  = '{1'b1, ADDR_IRQMASK, 32'h0000_0000, 32'h0,         1'b0, "mask_wr0"};
    vecs[10] = '{1'b1, ADDR_EDGESEL, 32'h0000_0000, 32'h0,         1'b0, "esel_wr0"};
    vecs[11] = '{1'b1, ADDR_EDGECAP, 32'hFFFF_FFFF, 32'h0,         1'b0, "ecap_wr_all"};
    vecs[12] = '{1'b0, ADDR_EDGECAP, 32'h0000_0000, 32'h0000_0000, 1'b0, "ecap_clr_all"};
    vecs[13] = '{1'b0, ADDR_IRQMASK, 32'h0000_0000, 32'h0000_0000, 1'b0, "mask_clr"};
    vecs[14] = '{1'b0, ADDR_EDGESEL, 32'h0000_0000, 32'h0000_0000, 1'b0, "esel_clr"};

    reset_n           = 1'b0;
    in_port           = 10'h3FF;
    bus_if.address    = ADDR_DATA;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;

    // Reset held, then DATA latency: sync 2 edges + 3 ticks (edges 4, 8, 12), readdata one later.
    step(3);
    check32("rst_rdata", bus_if.readdata, 32'h0);
    check32("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    while (ecnt < 3) step(1);
    check32("data_early", bus_if.readdata, 32'h0);
    while (ecnt < 12) step(1);
    check32("data_edge12", bus_if.readdata, 32'h0);
    step(1);
    check32("data_edge13", bus_if.readdata, 32'h0000_03FF);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].addr, rd);
        check32({vecs[i].name, "_rd"}, rd, vecs[i].exp_rd);
        check32({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
      end
    end

    // Debounce reject: 5-cycle pulses never give 3 equal samples at 4-cycle spacing.
    in_port[0] = 1'b0;
    step(20);
    expect_rd("bit0_low", ADDR_DATA, 32'h0000_03FE);
    expect_rd("bit0_fall_ignored", ADDR_EDGECAP, 32'h0);
    bus_if.address = ADDR_DATA;
    bad = 0;
    for (int seg = 0; seg < 8; seg++) begin
      in_port[0] = (seg % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (bus_if.readdata[0] !== 1'b0) bad++;
      end
    end
    check32("toggle_stable", 32'(bad), 32'h0);
    in_port[0] = 1'b1;
    found = 0;
    for (int c = 0; c < 16 && found == 0; c++) begin
      step(1);
      if (bus_if.readdata[0] === 1'b1) found = 1;
    end
    check32("hold_settles", 32'(found), 32'h1);
    expect_rd("toggle_ecap", ADDR_EDGECAP, 32'h0000_0001);
    bus_write(ADDR_EDGECAP, 32'h1);

    // Edge polarity.
    in_port[1] = 1'b0;
    step(20);
    expect_rd("fall_esel0", ADDR_EDGECAP, 32'h0);
    bus_write(ADDR_EDGESEL, 32'h2);
    expect_rd("esel_no_cap", ADDR_EDGECAP, 32'h0);
    in_port[1] = 1'b1;
    step(20);
    expect_rd("rise_esel1", ADDR_EDGECAP, 32'h0);
    in_port[1] = 1'b0;
    step(20);
    expect_rd("fall_esel1", ADDR_EDGECAP, 32'h0000_0002);
    bus_write(ADDR_EDGECAP, 32'h2);
    in_port[2] = 1'b0;
    step(20);
    expect_rd("bit2_fall", ADDR_EDGECAP, 32'h0);
    in_port[2] = 1'b1;
    step(20);
    expect_rd("bit2_rise", ADDR_EDGECAP, 32'h0000_0004);

    // irq and mask latency.
    check32("irq_masked", 32'(irq), 32'h0);
    bus_write(ADDR_IRQMASK, 32'h4);
    check32("irq_mask_lat0", 32'(irq), 32'h0);
    step(1);
    check32("irq_mask_lat1", 32'(irq), 32'h1);
    bus_write(ADDR_EDGECAP, 32'h4);
    check32("irq_clr_lat0", 32'(irq), 32'h1);
    step(1);
    check32("irq_clr_lat1", 32'(irq), 32'h0);
    expect_rd("ecap_after_clr", ADDR_EDGECAP, 32'h0);

    // Clear/edge collision: drive just after a tick edge, deb[3] rises at +12, hit at edge +13.
    in_port[3] = 1'b0;
    step(20);
    while (ecnt % 4 != 0) step(1);
    in_port[3] = 1'b1;
    step(12);
    bus_write(ADDR_EDGECAP, 32'h8);
    expect_rd("collision_edge_wins", ADDR_EDGECAP, 32'h0000_0008);

    // Reset mid-operation with irq high and bit 4 partially sampled.
    bus_write(ADDR_IRQMASK, 32'h8);
    step(1);
    check32("irq_pre_reset", 32'(irq), 32'h1);
    in_port[4] = 1'b0;
    step(6);
    reset_n = 1'b0;
    #1;
    check32("midrst_irq", 32'(irq), 32'h0);
    check32("midrst_rdata", bus_if.readdata, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_rd("midrst_mask", ADDR_IRQMASK, 32'h0);
    expect_rd("midrst_esel", ADDR_EDGESEL, 32'h0);
    expect_rd("midrst_ecap", ADDR_EDGECAP, 32'h0);
    bus_if.address = ADDR_DATA;
    while (ecnt < 12) step(1);
    check32("midrst_data_edge12", bus_if.readdata, 32'h0);
    step(1);
    check32("midrst_data_edge13", bus_if.readdata, 32'h0000_03ED);
    check32("midrst_irq_after", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_input_ctrl.md
Name: sw_input_ctrl

Overview:
- Avalon-MM slave controller for the DE0 slide-switch bank; replaces the raw switch PIO in the Qsys system.
- Synchronises and debounces the `in_port` switches and presents the stable value on a register read.
- Captures per-bit edges with selectable polarity and raises a maskable level interrupt to the Nios II.

Parameters:
- WIDTH, 10, number of switch inputs (1..32)
- TICK_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); must be >= 2
- DIV_W, 16, prescaler counter width; must satisfy 2^DIV_W > TICK_DIV

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  raw asynchronous switch inputs
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset values:
  - readdata = 0, irq = 0.
  - Sync flops, sample shift registers, debounced value, mask, edgesel and edgecapture all = 0.
  - Prescaler = 0.
- Reset mid-operation: all state returns to the reset values immediately; there is no partial-state retention.
- Input sync: 2-flop synchroniser per bit; `sync` is the second stage.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - `tick` is a 1-cycle pulse asserted when count == TICK_DIV-1.
- Debounce, per bit, on each tick:
  - Shift `sync` into a 3-deep sample register.
  - If all 3 samples are equal and differ from `deb[i]`, update `deb[i]` on the same clock edge.
  - Otherwise `deb[i]` holds.
  - Worst-case latency from a stable input change to `deb` = 2 sync cycles + 3 ticks.
- Edge detect:
  - `deb_q` is `deb` delayed one cycle.
  - rise = `deb & ~deb_q`, fall = `~deb & deb_q`.
  - `hit[i]` = edgesel[i] ? fall[i] : rise[i].
- Register map (word address):
  - 0 DATA: R; `deb` zero-extended to 32 bits. Writes are ignored.
  - 1 IRQMASK: R/W; bits [WIDTH-1:0].
  - 2 EDGESEL: R/W; per bit, 1 = capture falling edge, 0 = capture rising edge.
  - 3 EDGECAP: R / write-1-to-clear; bits [WIDTH-1:0].
  - Unused upper bits read 0 and are ignored on write.
- Bus timing:
  - Write occurs when chipselect && !write_n; the register updates on that clock edge.
  - Read: readdata is registered every cycle from the mux at `address`, giving 1-cycle read latency with zero wait states.
  - When chipselect = 0, readdata still follows the mux.
- EDGECAP update: `edgecap <= (edgecap & ~clr) | hit`.
  - `clr` = writedata[WIDTH-1:0] when EDGECAP is written, else 0.
  - If a new edge and a clear of the same bit occur in the same cycle, the bit ends up set (edge wins).
- Changing EDGESEL does not create a capture by itself; only `deb` transitions do.
- irq: registered; `irq <= |(edgecap & mask)`.
  - Asserts 1 cycle after edgecap or mask goes true.
  - Deasserts 1 cycle after the last contributing bit is cleared or masked.
- Simultaneous tick and bus access: independent; there is no stall.

Decomposition:
- Package `sw_input_ctrl_pkg`:
  - Register address constants ADDR_DATA = 0, ADDR_IRQMASK = 1, ADDR_EDGESEL = 2, ADDR_EDGECAP = 3.
  - Default TICK_DIV.
- Sub-module `sw_debounce_bit`, instantiated WIDTH times via generate.
  - Inputs: clk, reset_n, tick, raw.
  - Contains the 2-flop sync, 3-sample shift register and `deb` flop; output is `deb`.
- The prescaler, register file, edge capture and irq stay in the top.

Test Plan:
- Reset, then read each address:
  - Reset held, in_port = 10'h3FF: readdata = 0, irq = 0.
  - After release, with TICK_DIV = 4: read DATA within 3 cycles -> 0.
  - After 3 ticks plus sync (<= 15 cycles): read DATA -> 32'h3FF.
- Debounce reject, TICK_DIV = 4:
  - Toggle in_port[0] each 5 cycles for 40 cycles, then hold 1.
  - Required: DATA[0] never changes during the toggling, and becomes 1 within 3 ticks after the hold.
  - EDGECAP = 32'h1.
- Edge polarity:
  - Write EDGESEL = 32'h2; drive in_port[1] 0 -> 1 -> 0, each held 5 ticks.
  - Required: EDGECAP = 32'h2 only after the fall.
  - With in_port[2] 0 -> 1 and EDGESEL[2] = 0, EDGECAP[2] sets on the rise.
- irq and mask:
  - With EDGECAP = 32'h4 and IRQMASK = 0: irq = 0.
  - Write IRQMASK = 32'h4: irq = 1 one cycle later.
  - Write EDGECAP = 32'h4: irq = 0 one cycle later, and EDGECAP reads 0.
- Clear/edge collision:
  - Force the `deb[3]` rising edge in the same cycle as a write of EDGECAP = 32'h8.
  - Required: EDGECAP[3] reads 1 afterwards.
- Reset mid-operation:
  - Assert reset_n low for 1 cycle while a debounce is partially sampled and irq = 1.
  - Required: irq, readdata and all registers = 0 immediately, and the prescaler restarts from 0.
